// File: rtl/freq_cnt_pkg.sv
// Shared constants for the gated edge counter.
// FSM encoding and default widths.
package freq_cnt_pkg;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with one delay flop.
// Produces synced level plus single-cycle rise/fall.
module sync_edge_det
  import freq_cnt_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/gated_edge_counter.sv
// Counts sig_in rising edges per gate_in high phase.
// Define OVF_SAT_EN for saturating count and overflow flag.
module gated_edge_counter
  import freq_cnt_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             gate_in,
  input  logic             sig_in,
  input  logic             result_ack,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overrun,
`ifdef OVF_SAT_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [PRIME_W-1:0] prime_cnt;
  logic             primed;

  logic gate_lvl;
  logic gate_rise;
  logic gate_fall;
  logic sig_lvl;
  logic sig_rise;
  logic sig_fall;
  logic sig_unused;

`ifdef OVF_SAT_EN
  logic at_max;
  logic sat_hit;
`endif

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_gate_sync (
    .clock(clock),
    .reset(reset),
    .d    (gate_in),
    .level(gate_lvl),
    .rise (gate_rise),
    .fall (gate_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sig_sync (
    .clock(clock),
    .reset(reset),
    .d    (sig_in),
    .level(sig_lvl),
    .rise (sig_rise),
    .fall (sig_fall)
  );

  assign sig_unused = sig_lvl ^ sig_fall;

  // Cleared flops read as "gate low" until real samples arrive.
  assign primed = (prime_cnt == PRIME_W'(SYNC_STAGES));

  always_ff @(posedge clock) begin
    if (!reset) begin
      prime_cnt <= '0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + PRIME_W'(1);
    end
  end

`ifdef OVF_SAT_EN
  assign at_max = &count;
`endif

  always_comb begin
    count_inc = count + CNT_W'(1);
`ifdef OVF_SAT_EN
    if (at_max) count_inc = count;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
`ifdef OVF_SAT_EN
      sat_hit      <= 1'b0;
      overflow     <= 1'b0;
`endif
    end else begin
      if (result_ack && result_valid) begin
        result_valid <= 1'b0;
        overrun      <= 1'b0;
`ifdef OVF_SAT_EN
        overflow     <= 1'b0;
`endif
      end
      if (!enable) begin
        state <= IDLE;
        count <= '0;
`ifdef OVF_SAT_EN
        sat_hit <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            count <= '0;
            if (primed && !gate_lvl) state <= ARMED;
          end
          ARMED: begin
            if (gate_rise) begin
              state <= COUNT;
              count <= CNT_W'(sig_rise);
`ifdef OVF_SAT_EN
              sat_hit <= 1'b0;
`endif
            end
          end
          COUNT: begin
            if (gate_fall) begin
              state        <= ARMED;
              result       <= count;
              result_valid <= 1'b1;
              if (result_valid && !result_ack) overrun <= 1'b1;
`ifdef OVF_SAT_EN
              overflow     <= sat_hit;
`endif
            end else if (sig_rise) begin
              count <= count_inc;
`ifdef OVF_SAT_EN
              sat_hit <= sat_hit | at_max;
`endif
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

  assign busy = (state == ARMED) || (state == COUNT);

endmodule

// File: tb/tb_gated_edge_counter.sv
// Self-checking bench: window-level model plus literal checks.
// Runs a 32-bit and a 4-bit instance on shared stimulus.
module tb_gated_edge_counter;

  localparam int NS = 2;

  logic clock = 1'b0;
  logic reset, enable, gate_in, sig_in, result_ack;
  logic [31:0] result32;
  logic [3:0]  result4;
  logic v32, v4, o32, o4, b32, b4;
`ifdef OVF_SAT_EN
  logic f32, f4;
`endif

  always #5 clock = ~clock;

  gated_edge_counter #(.CNT_W(32), .SYNC_STAGES(NS)) dut32 (
    .clock(clock), .reset(reset), .enable(enable),
    .gate_in(gate_in), .sig_in(sig_in), .result_ack(result_ack),
    .result(result32), .result_valid(v32), .overrun(o32),
`ifdef OVF_SAT_EN
    .overflow(f32),
`endif
    .busy(b32)
  );

  gated_edge_counter #(.CNT_W(4), .SYNC_STAGES(NS)) dut4 (
    .clock(clock), .reset(reset), .enable(enable),
    .gate_in(gate_in), .sig_in(sig_in), .result_ack(result_ack),
    .result(result4), .result_valid(v4), .overrun(o4),
`ifdef OVF_SAT_EN
    .overflow(f4),
`endif
    .busy(b4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: delayed input history, window phase, unbounded edge total.
  bit [NS:0] hg, hs, hv;
  int     phase;
  longint edges;
  longint m_res;
  bit     m_valid, m_ovr, m_ovf;
  bit     model_on = 1'b0;

  always @(posedge clock) begin : model
    bit lg, pg, ls, ps, lv, gr, gf, sr, old_v;
    if (!reset) begin
      phase = 0; edges = 0; m_res = 0;
      m_valid = 0; m_ovr = 0; m_ovf = 0;
      hg = '0; hs = '0; hv = '0;
      model_on = 1'b1;
    end else begin
      lg = hg[NS-1]; pg = hg[NS];
      ls = hs[NS-1]; ps = hs[NS];
      lv = hv[NS-1];
      gr = lg && !pg; gf = !lg && pg; sr = ls && !ps;
      old_v = m_valid;
      if (result_ack && old_v) begin
        m_valid = 0; m_ovr = 0; m_ovf = 0;
      end
      if (!enable) begin
        phase = 0; edges = 0;
      end else begin
        case (phase)
          0: if (lv && !lg) phase = 1;
          1: if (gr) begin phase = 2; edges = sr ? 1 : 0; end
          default: begin
            if (gf) begin
              m_res = edges; m_valid = 1; m_ovf = (edges > 15);
              if (old_v && !result_ack) m_ovr = 1;
              phase = 1;
            end else if (sr) edges++;
          end
        endcase
      end
      hg = {hg[NS-1:0], gate_in};
      hs = {hs[NS-1:0], sig_in};
      hv = {hv[NS-1:0], 1'b1};
    end
  end

  function automatic longint exp4(longint e);
`ifdef OVF_SAT_EN
    return (e > 15) ? 15 : e;
`else
    return e % 16;
`endif
  endfunction

  always @(negedge clock) begin
    if (model_on) begin
      chk("result32", result32, m_res[31:0]);
      chk("result4", result4, exp4(m_res));
      chk("valid32", v32, m_valid);
      chk("valid4", v4, m_valid);
      chk("overrun32", o32, m_ovr);
      chk("overrun4", o4, m_ovr);
      chk("busy32", b32, phase != 0);
      chk("busy4", b4, phase != 0);
`ifdef OVF_SAT_EN
      chk("overflow32", f32, 1'b0);
      chk("overflow4", f4, m_ovf);
`endif
    end
  end

  task automatic cyc(bit g, bit s, bit a);
    gate_in = g; sig_in = s; result_ack = a;
    @(negedge clock);
  endtask

  task automatic win(int high, int low, int p);
    for (int i = 0; i < high; i++) cyc(1'b1, (i % p) < p / 2, 1'b0);
    for (int i = 0; i < low; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 0; enable = 0; gate_in = 1; sig_in = 0; result_ack = 0;
    @(negedge clock);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("rst_result", result32, 0);
    chk("rst_valid", v32, 0);
    chk("rst_overrun", o32, 0);
    chk("rst_busy", b32, 0);

    // Reset released mid-window: nothing may be latched.
    reset = 1; enable = 1;
    for (int i = 0; i < 30; i++) cyc(1'b1, (i % 4) < 2, 1'b0);
    chk("partial_busy_idle", b32, 0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("partial_valid", v32, 0);
    chk("partial_armed", b32, 1);

    win(100, 20, 4);
    chk("w1_result", result32, 25);
    chk("w1_valid", v32, 1);
    chk("w1_overrun", o32, 0);
`ifdef OVF_SAT_EN
    chk("w1_result4", result4, 15);
    chk("w1_overflow4", f4, 1);
`else
    chk("w1_result4", result4, 9);
`endif
    cyc(1'b0, 1'b0, 1'b1);
    chk("ack_valid", v32, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // Sig rise coincident with gate rise is counted.
    repeat (2) cyc(1'b1, 1'b1, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("rise_edge_result", result32, 1);
    cyc(1'b0, 1'b0, 1'b1);

    // Sig rise coincident with gate fall is not counted.
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    repeat (18) cyc(1'b0, 1'b0, 1'b0);
    chk("fall_edge_result", result32, 0);
    chk("fall_edge_valid", v32, 1);
    chk("fall_edge_overrun", o32, 0);

    win(80, 20, 4);
    chk("ovr_result", result32, 20);
    chk("ovr_overrun", o32, 1);
`ifdef OVF_SAT_EN
    chk("ovr_result4", result4, 15);
    chk("ovr_overflow4", f4, 1);
`else
    chk("ovr_result4", result4, 4);
`endif

    // Ack lands on the latch edge.
    for (int i = 0; i < 40; i++) cyc(1'b1, (i % 4) < 2, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("coinc_valid", v32, 1);
    chk("coinc_overrun", o32, 0);
    chk("coinc_result", result32, 10);
    repeat (17) cyc(1'b0, 1'b0, 1'b0);

    win(20, 20, 4);
    chk("c_result", result32, 5);
    chk("c_overrun", o32, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ack_alone_valid", v32, 0);
    chk("ack_alone_overrun", o32, 0);
    cyc(1'b0, 1'b0, 1'b0);

    win(12, 20, 4);
    chk("d_result", result32, 3);
    chk("d_overrun", o32, 0);

    // One-cycle enable drop mid-window.
    for (int i = 0; i < 10; i++) cyc(1'b1, (i % 4) < 2, 1'b0);
    enable = 0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("abort_busy", b32, 0);
    chk("abort_result", result32, 3);
    chk("abort_valid", v32, 1);
    enable = 1;
    for (int i = 0; i < 10; i++) cyc(1'b1, (i % 4) < 2, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("post_abort_result", result32, 3);
    chk("post_abort_armed", b32, 1);
    chk("post_abort_overrun", o32, 0);

    win(16, 20, 4);
    chk("e_result", result32, 4);
    chk("e_overrun", o32, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gated_edge_counter.md
Name: gated_edge_counter

Overview:
Counts rising edges of an asynchronous signal-under-test during each high phase of the one-second gate from the gate divider. Latches the total as a frequency result in Hz and offers it to the downstream reader over a valid/ack handshake. Sits directly downstream of the gate divider and upstream of the MSS/APB result register. Both gate_in and sig_in are treated as asynchronous to clock.

Parameters:
CNT_W, 32, width of edge counter and result.
SYNC_STAGES, 2, flip-flop synchronizer depth for gate_in and sig_in (minimum 2).

Ports:
clock  input  1  measurement clock.
reset  input  1  synchronous, active-low.
enable  input  1  1 = measurement allowed; 0 = abort any window and return to IDLE.
gate_in  input  1  gate from divider; high = counting window.
sig_in  input  1  signal under test, asynchronous.
result_ack  input  1  reader consumed result; single-cycle pulse.
result  output  CNT_W  edge count of last completed window.
result_valid  output  1  result holds an unconsumed value.
overrun  output  1  sticky: a result was overwritten before ack.
busy  output  1  high in ARMED or COUNT.

Behaviour:
- Reset (reset=0 at posedge clock): state=IDLE, count=0, result=0, result_valid=0, overrun=0, busy=0. Synchronizer flops are cleared to 0.
- Sync/edge: each input passes through SYNC_STAGES flops plus one delay flop.
  - s_rise = s & ~s_d; s_fall = ~s & s_d.
  - Input-to-detect latency is SYNC_STAGES+1 cycles.
- sig_in maximum measurable frequency is below clock/2; above that the count is undefined.
- FSM:
  - IDLE: wait for synced gate = 0, then go to ARMED. This prevents counting a partial window after enable or reset.
  - ARMED: on gate_rise go to COUNT. count <= 1 if sig_rise in the same cycle, else 0.
  - COUNT: count increments by 1 per sig_rise.
    - On gate_fall: result <= count, result_valid <= 1, go to ARMED.
    - A sig_rise in the gate_fall cycle is NOT counted.
  - enable=0 in any state: next state IDLE, count cleared. result, result_valid and overrun are unaffected.
- Result latency: result_valid rises on the clock edge at which gate_fall is detected. result is stable while result_valid=1 unless overwritten.
- Handshake:
  - result_ack with result_valid=1 clears result_valid next cycle and clears overrun.
  - result_ack with result_valid=0 is ignored.
  - New latch while result_valid=1 and no ack: result overwritten, overrun <= 1.
  - New latch and result_ack in the same cycle: latch wins, result_valid stays 1, overrun <= 0.
- Width: count wraps modulo 2^CNT_W (default build).
- busy = (state==ARMED || state==COUNT).

Optional Feature:
Macro OVF_SAT_EN.
- Defined:
  - count saturates at 2^CNT_W-1.
  - Extra output overflow (1 bit) is latched with result: 1 if saturation occurred in that window.
  - overflow resets to 0 and is held/cleared with result_valid semantics (cleared on ack).
- Undefined: the overflow port is absent and count wraps silently.

Decomposition:
- Package freq_cnt_pkg holds:
  - FSM state encoding: IDLE=2'd0, ARMED=2'd1, COUNT=2'd2.
  - Default CNT_W and SYNC_STAGES constants.
- Sub-module sync_edge_det (parameter SYNC_STAGES; outputs level, rise, fall), instantiated once for gate_in and once for sig_in.

Test Plan:
- Reset/basic: gate high 100 cycles, low 100, sig_in period 4 cycles -> result=25, result_valid=1 at synced gate fall; overrun=0.
- Partial window: release reset while gate_in high mid-window -> no result from that window; the first result comes after a full low-high-low sequence.
- Boundary edges: sig rise aligned to the synced gate_rise cycle -> counted; aligned to the synced gate_fall cycle -> not counted. Expected counts 1 and 0 for a single-pulse window.
- Handshake/overrun:
  - Two windows with no ack -> result = second count, overrun=1.
  - Ack alone -> result_valid=0 and overrun=0 next cycle.
  - Ack coincident with a latch -> result_valid stays 1, overrun=0.
- Abort: drop enable for 1 cycle mid-COUNT -> count discarded, state IDLE, previous result and result_valid unchanged, busy=0.
- Wrap/saturate (CNT_W=4): 20 edges in a window -> result=4 without OVF_SAT_EN; with OVF_SAT_EN, result=15 and overflow=1.
